regfile_mp: RTL

Parametrised multi-port register file that succeeds the single-write, three-read write-first regfile.
- Configurable data width, depth, read-port count and write-port count.
- Write-first bypass on every read port, with a fixed write-port priority.
- Sequential bulk-clear engine, started on reset and on request; `busy` is high while it runs.
- Sits in the CPU decode stage; read ports feed operand select, write ports come from the writeback stage(s).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_bypass.sv | 44 ++++
 rtl/regfile_mp.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefAw = 5;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: write ports, read ports, clear control.
// Scoreboard signals exist only when REGFILE_MP_SCOREBOARD_EN is defined.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw,
  parameter int unsigned NR = 3,
  parameter int unsigned NW = 2
);

  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic             clr_req;
  logic             busy;
`ifdef REGFILE_MP_SCOREBOARD_EN
  logic             alloc_en;
  logic [AW-1:0]    alloc_a;
  logic [NR-1:0]    rdy;

  modport master (output we, wa, wd, ra, clr_req, alloc_en, alloc_a,
                  input  rd, busy, rdy);
  modport slave  (input  we, wa, wd, ra, clr_req, alloc_en, alloc_a,
                  output rd, busy, rdy);
`else
  modport master (output we, wa, wd, ra, clr_req,
                  input  rd, busy);
  modport slave  (input  we, wa, wd, ra, clr_req,
                  output rd, busy);
`endif

endinterface

// File: rtl/regfile_bypass.sv
// One read port: write-first bypass with highest-index write port winning,
// entry-0 forced to zero, and output held at zero while a clear runs.
module regfile_bypass #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NW       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]    ra_i,
  input  logic [NW-1:0]    we_i,
  input  logic [NW*AW-1:0] wa_i,
  input  logic [NW*DW-1:0] wd_i,
  input  logic [DW-1:0]    word_i,
  input  logic             busy_i,
  output logic [DW-1:0]    rd_o,
  output logic             hit_o
);

  logic          hit;
  logic          blocked;
  logic [DW-1:0] byp;

  always_comb begin
    hit = 1'b0;
    byp = '0;
    // Ascending scan so the highest-index matching port is the one kept.
    for (int k = 0; k < int'(NW); k++) begin
      if (we_i[k] && (wa_i[k*AW +: AW] == ra_i)) begin
        hit = 1'b1;
        byp = wd_i[k*DW +: DW];
      end
    end
    blocked = busy_i || (ZERO_REG && (ra_i == '0));
    hit_o   = hit && !blocked;
    if (blocked) begin
      rd_o = '0;
    end else if (hit) begin
      rd_o = byp;
    end else begin
      rd_o = word_i;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port write-first register file with a sequential bulk-clear
// engine. Define REGFILE_MP_SCOREBOARD_EN to add the pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DefDw,
  parameter int unsigned AW       = DefAw,
  parameter int unsigned NR       = 3,
  parameter int unsigned NW       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;

  state_e        state_q, state_d;
  logic [AW-1:0] cptr_q, cptr_d;
  logic          busy;
  logic [NW-1:0] wcommit;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_w [NR];
  logic [NR-1:0] hit;

  assign busy     = (state_q == StClear);
  assign bus.busy = busy;

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d = StClear;
          cptr_d  = '0;
        end
      end
      StClear: begin
        cptr_d = cptr_q + AW'(1);
        if (cptr_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // Writes only land in idle; entry 0 is read-only zero when ZERO_REG is set.
  always_comb begin
    wcommit = '0;
    for (int k = 0; k < int'(NW); k++) begin
      wcommit[k] = bus.we[k] && !busy && !(ZERO_REG && (bus.wa[k*AW +: AW] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cptr_q] <= '0;
    end else begin
      for (int k = 0; k < int'(NW); k++) begin
        if (wcommit[k]) begin
          mem_q[bus.wa[k*AW +: AW]] <= bus.wd[k*DW +: DW];
        end
      end
    end
  end

  for (genvar j = 0; j < int'(NR); j++) begin : g_rd
    regfile_bypass #(
      .DW       (DW),
      .AW       (AW),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .ra_i   (bus.ra[j*AW +: AW]),
      .we_i   (bus.we),
      .wa_i   (bus.wa),
      .wd_i   (bus.wd),
      .word_i (mem_q[bus.ra[j*AW +: AW]]),
      .busy_i (busy),
      .rd_o   (rd_w[j]),
      .hit_o  (hit[j])
    );
  end

  always_comb begin
    bus.rd = '0;
    for (int j = 0; j < int'(NR); j++) begin
      bus.rd[j*DW +: DW] = rd_w[j];
    end
  end

`ifdef REGFILE_MP_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (busy) begin
      pending_d = '0;
    end else begin
      for (int k = 0; k < int'(NW); k++) begin
        if (wcommit[k]) begin
          pending_d[bus.wa[k*AW +: AW]] = 1'b0;
        end
      end
      // Applied after the write clears so a same-cycle alloc stays pending.
      if (bus.alloc_en) begin
        pending_d[bus.alloc_a] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    bus.rdy = '0;
    for (int j = 0; j < int'(NR); j++) begin
      if (busy) begin
        bus.rdy[j] = 1'b0;
      end else if (ZERO_REG && (bus.ra[j*AW +: AW] == '0)) begin
        bus.rdy[j] = 1'b1;
      end else begin
        bus.rdy[j] = !pending_q[bus.ra[j*AW +: AW]] || hit[j];
      end
    end
  end
`else
  logic unused_hit;
  assign unused_hit = ^hit;
`endif

endmodule
